// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/half/word load-store requests onto a 16-bit word RAM,
// using read-modify-write for byte stores and returning one response per request.
module mem_access_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W:0]   req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              ram_write_n,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata
);
   typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
   state_t              state_q, state_d;
   logic                we_q, uns_q, a0_q, err_q;
   logic [1:0]          size_q;
   logic [7:0]          byte_q;
   logic [15:0]         hi_q, rd0_q, rd1_q;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [15:0]         ram_wdata_q, ram_wdata_d;
   logic                req_err, accept;
   logic [7:0]          ld_byte;
   logic [31:0]         ld_data;
   assign req_err = (req_size == 2'd3) | ((req_size == 2'd1) & req_addr[0]) |
                    ((req_size == 2'd2) & (|req_addr[1:0]));
   assign accept  = req_valid & (state_q == IDLE);
   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = req_err ? RESP : (req_we && req_size != 2'd0) ? WR0 : RD0;
            if (!req_err) ram_addr_d = req_addr[ADDR_W:1];
            if (!req_err && req_we && req_size != 2'd0) ram_wdata_d = req_wdata[15:0];
         end
         RD0: begin
            state_d = we_q ? WR0 : (size_q == 2'd2) ? RD1 : RESP;
            if (!we_q && size_q == 2'd2) ram_addr_d = ram_addr_q + 1'b1;
            // byte store: merge the new byte into the word just read
            if (we_q) ram_wdata_d = a0_q ? {byte_q, ram_rdata[7:0]} : {ram_rdata[15:8], byte_q};
         end
         RD1: state_d = RESP;
         WR0: begin
            state_d = (size_q == 2'd2) ? WR1 : RESP;
            if (size_q == 2'd2) begin
               ram_addr_d  = ram_addr_q + 1'b1;
               ram_wdata_d = hi_q;
            end
         end
         WR1: state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         a0_q        <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= 2'd0;
         byte_q      <= 8'd0;
         hi_q        <= 16'd0;
         rd0_q       <= 16'd0;
         rd1_q       <= 16'd0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if (accept) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            a0_q   <= req_addr[0];
            err_q  <= req_err;
            size_q <= req_size;
            byte_q <= req_wdata[7:0];
            hi_q   <= req_wdata[31:16];
         end
         if (state_q == RD0) rd0_q <= ram_rdata;
         if (state_q == RD1) rd1_q <= ram_rdata;
      end
   end
   assign ld_byte = a0_q ? rd0_q[15:8] : rd0_q[7:0];
   assign ld_data = (size_q == 2'd0) ? {{24{~uns_q & ld_byte[7]}}, ld_byte} :
                    (size_q == 2'd1) ? {{16{~uns_q & rd0_q[15]}}, rd0_q} : {rd1_q, rd0_q};
   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign resp_err    = (state_q == RESP) & err_q;
   assign resp_rdata  = (state_q == RESP && !we_q && !err_q) ? ld_data : 32'd0;
   assign ram_write_n = ~(rst_n & ((state_q == WR0) | (state_q == WR1)));
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
endmodule
